// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter
//   Shares one combinational ALU between two requesters. A winning request
//   is captured in IDLE, presented to the ALU from registers for exactly one
//   EXEC cycle, and the registered result is offered on a tagged response
//   channel in RESP until the consumer takes it.
//
//   Optional feature macro: ALU_ARB_ROUND_ROBIN_EN
//     defined   : on contention the requester that did not win last time is
//                 granted (strict alternation).
//     undefined : fixed priority, requester 0 always wins contention.
module alu_share_arbiter #(
  parameter int DATA_W = 32,
  parameter int OP_W   = 4
) (
  input  logic              clk,
  input  logic              reset,

  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [OP_W-1:0]   req0_op,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,

  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [OP_W-1:0]   req1_op,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,

  output logic              resp_valid,
  input  logic              resp_ready,
  output logic              resp_id,
  output logic [DATA_W-1:0] resp_data,
  output logic              resp_zero,

  output logic [OP_W-1:0]   alu_control,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  input  logic [DATA_W-1:0] alu_out,
  input  logic              alu_zero,

  output logic              busy
);

  // Arbitration mode resolved at elaboration so last_grant_q is always
  // read, even when fixed priority ignores it.
`ifdef ALU_ARB_ROUND_ROBIN_EN
  localparam bit ROUND_ROBIN = 1'b1;
`else
  localparam bit ROUND_ROBIN = 1'b0;
`endif

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t              state_q, state_d;

  // Captured operation; these registers drive the ALU directly.
  logic [OP_W-1:0]     op_q, op_d;
  logic [DATA_W-1:0]   a_q, a_d;
  logic [DATA_W-1:0]   b_q, b_d;
  logic                id_q, id_d;
  logic                last_grant_q, last_grant_d;

  // Registered response.
  logic [DATA_W-1:0]   resp_data_q, resp_data_d;
  logic                resp_zero_q, resp_zero_d;
  logic                resp_id_q, resp_id_d;

  // Arbitration signals.
  logic                idle;
  logic                grant_valid;
  logic                grant_id;
  logic                contention_pick;
  logic                accept;

  assign idle = (state_q == IDLE);

  // Grant: a lone requester wins outright; contention follows the mode.
  always_comb begin
    grant_valid     = req0_valid | req1_valid;
    contention_pick = ROUND_ROBIN ? ~last_grant_q : 1'b0;
    grant_id        = 1'b0;
    if (req0_valid && req1_valid) begin
      grant_id = contention_pick;
    end else if (req1_valid) begin
      grant_id = 1'b1;
    end
  end

  // Ready only in IDLE and only towards the granted, valid requester.
  always_comb begin
    req0_ready = idle & grant_valid & ~grant_id;
    req1_ready = idle & grant_valid &  grant_id;
    accept     = (req0_valid & req0_ready) | (req1_valid & req1_ready);
  end

  // Next-state logic for the IDLE -> EXEC -> RESP -> IDLE sequence.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = EXEC;
        end
      end
      EXEC: begin
        state_d = RESP;
      end
      RESP: begin
        if (resp_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Operand capture on handshake; values hold otherwise so the ALU inputs
  // stay at the last latched operation outside EXEC.
  always_comb begin
    op_d         = op_q;
    a_d          = a_q;
    b_d          = b_q;
    id_d         = id_q;
    last_grant_d = last_grant_q;
    if (accept) begin
      id_d         = grant_id;
      last_grant_d = grant_id;
      if (grant_id) begin
        op_d = req1_op;
        a_d  = req1_a;
        b_d  = req1_b;
      end else begin
        op_d = req0_op;
        a_d  = req0_a;
        b_d  = req0_b;
      end
    end
  end

  // Response capture: ALU result is sampled only at the end of EXEC, so the
  // response stays stable for the whole RESP phase.
  always_comb begin
    resp_data_d = resp_data_q;
    resp_zero_d = resp_zero_q;
    resp_id_d   = resp_id_q;
    if (state_q == EXEC) begin
      resp_data_d = alu_out;
      resp_zero_d = alu_zero;
      resp_id_d   = id_q;
    end
  end

  // State register; reset discards any in-flight operation.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Captured-operation registers; last_grant resets to 1 so that
  // requester 0 wins the first contention.
  always_ff @(posedge clk) begin
    if (reset) begin
      op_q         <= '0;
      a_q          <= '0;
      b_q          <= '0;
      id_q         <= 1'b0;
      last_grant_q <= 1'b1;
    end else begin
      op_q         <= op_d;
      a_q          <= a_d;
      b_q          <= b_d;
      id_q         <= id_d;
      last_grant_q <= last_grant_d;
    end
  end

  // Response registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      resp_data_q <= '0;
      resp_zero_q <= 1'b0;
      resp_id_q   <= 1'b0;
    end else begin
      resp_data_q <= resp_data_d;
      resp_zero_q <= resp_zero_d;
      resp_id_q   <= resp_id_d;
    end
  end

  assign alu_control = op_q;
  assign alu_a       = a_q;
  assign alu_b       = b_q;

  assign resp_valid  = (state_q == RESP);
  assign resp_id     = resp_id_q;
  assign resp_data   = resp_data_q;
  assign resp_zero   = resp_zero_q;

  assign busy        = ~idle;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Bench for alu_share_arbiter: a stub ALU closes the loop, a transaction-level
// model predicts every output each cycle, and directed sequences pin literal
// results, latency, backpressure, contention order and mid-operation reset.
module tb_alu_share_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        req0_valid, req0_ready;
  logic [3:0]  req0_op;
  logic [31:0] req0_a, req0_b;
  logic        req1_valid, req1_ready;
  logic [3:0]  req1_op;
  logic [31:0] req1_a, req1_b;
  logic        resp_valid, resp_ready, resp_id, resp_zero;
  logic [31:0] resp_data;
  logic [3:0]  alu_control;
  logic [31:0] alu_a, alu_b, alu_out;
  logic        alu_zero;
  logic        busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_share_arbiter #(.DATA_W(32), .OP_W(4)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
    .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
    .req1_a(req1_a), .req1_b(req1_b),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
    .resp_data(resp_data), .resp_zero(resp_zero),
    .alu_control(alu_control), .alu_a(alu_a), .alu_b(alu_b),
    .alu_out(alu_out), .alu_zero(alu_zero), .busy(busy)
  );

  // Reference ALU behaviour; undefined codes give all ones.
  function automatic logic [31:0] alu_fn(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      4'h0: return a + b;
      4'h1: return a - b;
      4'h2: return a ^ b;
      4'h3: return a | b;
      4'h4: return a & b;
      4'h5: return ~a;
      4'h6: return a << b[4:0];
      4'h7: return a >> b[4:0];
      4'h8: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      default: return 32'hFFFF_FFFF;
    endcase
  endfunction

  // Stub ALU instance fed by the DUT.
  always_comb begin
    alu_out  = alu_fn(alu_control, alu_a, alu_b);
    alu_zero = (alu_out == 32'd0);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- transaction-level model ----------------
  bit          m_live = 0;
  bit          m_inflight;
  int          m_age;
  bit          m_last;
  logic [3:0]  m_op;
  logic [31:0] m_a, m_b;
  bit          m_id;
  bit          m_rid;
  logic [31:0] m_rdata;
  bit          m_rzero;

  // Which requester wins when the arbiter is free.
  function automatic bit winner(input bit v0, input bit v1, input bit last);
    if (v0 && v1) begin
`ifdef ALU_ARB_ROUND_ROBIN_EN
      return !last;
`else
      return 1'b0;
`endif
    end
    return v1;
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      m_live = 1; m_inflight = 0; m_age = 0; m_last = 1;
      m_op = 0; m_a = 0; m_b = 0; m_id = 0;
      m_rid = 0; m_rdata = 0; m_rzero = 0;
    end else if (m_live) begin
      if (!m_inflight) begin
        if (req0_valid || req1_valid) begin
          m_id = winner(req0_valid, req1_valid, m_last);
          m_last = m_id;
          m_op = m_id ? req1_op : req0_op;
          m_a  = m_id ? req1_a  : req0_a;
          m_b  = m_id ? req1_b  : req0_b;
          m_inflight = 1; m_age = 0;
        end
      end else if (m_age == 0) begin
        m_rdata = alu_fn(m_op, m_a, m_b);
        m_rzero = (m_rdata == 32'd0);
        m_rid = m_id;
        m_age = 1;
      end else if (resp_ready) begin
        m_inflight = 0;
      end
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (m_live) begin
      bit w;
      w = winner(req0_valid, req1_valid, m_last);
      chk("busy",        busy,        m_inflight);
      chk("req0_ready",  req0_ready,  !m_inflight && req0_valid && !w);
      chk("req1_ready",  req1_ready,  !m_inflight && req1_valid && w);
      chk("resp_valid",  resp_valid,  m_inflight && m_age == 1);
      chk("resp_id",     resp_id,     m_rid);
      chk("resp_data",   resp_data,   m_rdata);
      chk("resp_zero",   resp_zero,   m_rzero);
      chk("alu_control", alu_control, m_op);
      chk("alu_a",       alu_a,       m_a);
      chk("alu_b",       alu_b,       m_b);
    end
  end

  // ---------------- directed helpers ----------------
  task automatic set_req(input bit id, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    if (id) begin
      req1_valid = 1; req1_op = op; req1_a = a; req1_b = b;
    end else begin
      req0_valid = 1; req0_op = op; req0_a = a; req0_b = b;
    end
  endtask

  // Issue one op, check acceptance, 2-cycle latency and literal result.
  task automatic run_op(input bit id, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_d, input bit exp_z, input string nm);
    bit got;
    int lat;
    @(posedge clk); #1;
    resp_ready = 1;
    set_req(id, op, a, b);
    got = 0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (id ? req1_ready : req0_ready) begin got = 1; break; end
    end
    chk({nm, "_accept"}, got, 1);
    @(posedge clk); #1;
    req0_valid = 0; req1_valid = 0;
    got = 0; lat = 0;
    for (int n = 1; n <= 10; n++) begin
      @(negedge clk);
      if (resp_valid) begin got = 1; lat = n; break; end
    end
    chk({nm, "_resp"}, got, 1);
    chk({nm, "_latency"}, lat, 2);
    chk({nm, "_id"}, resp_id, id);
    chk({nm, "_data"}, resp_data, exp_d);
    chk({nm, "_zero"}, resp_zero, exp_z);
    $display("txn %s: id=%0d op=%h a=%h b=%h -> data=%h zero=%0d", nm, id, op, a, b, resp_data, resp_zero);
  endtask

  initial begin
    #400000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    bit got;
    int n_resp, r1seen, rv_cnt;
    bit seq [8];
    bit exp_w;

    reset = 1; resp_ready = 0;
    req0_valid = 0; req0_op = 0; req0_a = 0; req0_b = 0;
    req1_valid = 0; req1_op = 0; req1_a = 0; req1_b = 0;
    repeat (3) @(posedge clk);
    #1 reset = 0;
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_resp_data", resp_data, 0);
    chk("rst_resp_id", resp_id, 0);
    chk("rst_alu_a", alu_a, 0);
    chk("rst_alu_control", alu_control, 0);

    run_op(0, 4'h0, 32'd5, 32'd7, 32'd12, 0, "add_r0");
    run_op(1, 4'h1, 32'd9, 32'd9, 32'd0, 1, "sub_r1");
    run_op(1, 4'h8, 32'd3, 32'd4, 32'd1, 0, "slt_r1");
    run_op(0, 4'hF, 32'd3, 32'd4, 32'hFFFF_FFFF, 0, "undef_r0");
    run_op(0, 4'h6, 32'd1, 32'd31, 32'h8000_0000, 0, "sll_r0");

    // Backpressure: response held for 5 cycles while both requesters wait.
    @(posedge clk); #1;
    resp_ready = 0;
    set_req(0, 4'h0, 32'd100, 32'd23);
    got = 0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (req0_ready) begin got = 1; break; end
    end
    chk("bp_accept", got, 1);
    @(posedge clk); #1;
    set_req(1, 4'h2, 32'hA5A5_0000, 32'h0000_5A5A);
    got = 0;
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      if (resp_valid) begin got = 1; break; end
    end
    chk("bp_resp", got, 1);
    for (int k = 0; k < 5; k++) begin
      if (k > 0) @(negedge clk);
      chk("bp_valid", resp_valid, 1);
      chk("bp_data", resp_data, 32'd123);
      chk("bp_id", resp_id, 0);
      chk("bp_ready0", req0_ready, 0);
      chk("bp_ready1", req1_ready, 0);
      chk("bp_busy", busy, 1);
    end
    resp_ready = 1;
    @(posedge clk); #1;
    @(negedge clk);
`ifdef ALU_ARB_ROUND_ROBIN_EN
    exp_w = 1;
`else
    exp_w = 0;
`endif
    chk("bp_next_ready0", req0_ready, !exp_w);
    chk("bp_next_ready1", req1_ready, exp_w);
    $display("txn backpressure: data=%h id=%0d held 5 cycles", resp_data, resp_id);
    @(posedge clk); #1;
    req0_valid = 0; req1_valid = 0;
    repeat (4) @(posedge clk);

    // Reset while the op is in EXEC: it must vanish.
    #1;
    set_req(0, 4'h6, 32'd1, 32'd4);
    got = 0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (req0_ready) begin got = 1; break; end
    end
    chk("rx_accept", got, 1);
    @(posedge clk); #1;
    req0_valid = 0; reset = 1;
    @(posedge clk); #1;
    reset = 0;
    @(negedge clk);
    chk("rx_valid", resp_valid, 0);
    chk("rx_data", resp_data, 0);
    chk("rx_busy", busy, 0);
    rv_cnt = 0;
    for (int n = 0; n < 8; n++) begin
      @(negedge clk);
      if (resp_valid) rv_cnt++;
    end
    chk("rx_no_resp", rv_cnt, 0);
    $display("txn reset_in_exec: op discarded");

    // Contention: both valid continuously from a fresh reset.
    @(posedge clk); #1 reset = 1;
    @(posedge clk); #1 reset = 0;
    resp_ready = 1;
    set_req(0, 4'h0, 32'd1, 32'd1);
    set_req(1, 4'h0, 32'd2, 32'd2);
    n_resp = 0; r1seen = 0;
    for (int c = 0; c < 80 && n_resp < 8; c++) begin
      @(negedge clk);
      if (req1_ready) r1seen++;
      if (resp_valid) begin seq[n_resp] = resp_id; n_resp++; end
    end
    chk("cont_count", n_resp, 8);
    for (int i = 0; i < 8; i++) begin
`ifdef ALU_ARB_ROUND_ROBIN_EN
      chk("cont_seq", seq[i], i % 2);
`else
      chk("cont_seq", seq[i], 0);
`endif
    end
`ifdef ALU_ARB_ROUND_ROBIN_EN
    chk("cont_r1_grants", r1seen, 4);
`else
    chk("cont_r1_grants", r1seen, 0);
`endif
    $display("txn contention: %0d responses, req1 granted %0d times", n_resp, r1seen);
    @(posedge clk); #1;
    req0_valid = 0; req1_valid = 0;
    repeat (4) @(posedge clk);

    // Randomized traffic; the model checks every cycle.
    for (int c = 0; c < 3000; c++) begin
      #1;
      reset      = ($urandom_range(0, 299) == 0);
      req0_valid = ($urandom_range(0, 2) != 0);
      req1_valid = ($urandom_range(0, 2) != 0);
      req0_op    = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(9, 15)) : 4'($urandom_range(0, 8));
      req1_op    = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(9, 15)) : 4'($urandom_range(0, 8));
      req0_a     = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
      req0_b     = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
      req1_a     = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
      req1_b     = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
      resp_ready = ($urandom_range(0, 3) != 0);
      @(posedge clk);
    end
    #1;
    reset = 0; req0_valid = 0; req1_valid = 0; resp_ready = 1;
    repeat (6) @(posedge clk);
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
